sap_controller: RTL and testbench
=================================

SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 The block SHALL have one clock, `clock`, and one reset, `reset`; reset is asynchronous and active-high.
REQ-002 Ports SHALL be:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bus_in`  in  8  value currently on the shared bus; sampled into the instruction register (IR).
- `ir_operand`  out  4  IR[3:0]; the bus driver places it on bus[3:0] while `ir_out`=1.
- `opcode`  out  4  IR[7:4].
- `t_state`  out  6  one-hot step: bit0=T1 … bit5=T6; all zero while halted.
- `pc_out`, `pc_inc`, `mar_in`, `ram_out`, `ir_out`, `a_in`, `a_out`, `b_in`, `alu_out`, `sub`, `out_in`  out  1 each  control-word strobes, active-high.
- `halt`  out  1  high while the sequencer is stopped by HLT.

Function
REQ-003 The sequencer SHALL have seven states: T1–T6 in a ring, plus HALT.
REQ-004 Transitions: T1→T2→T3→T4→T5→T6→T1, one step per clock; HALT→HALT.
REQ-005 Every control output SHALL be a combinational (Moore) decode of the current state and IR only; no output depends on `bus_in`.
REQ-006 IR SHALL load `bus_in` on the rising edge that ends T3, and SHALL hold its value in every other state.
REQ-007 Fetch states, for every opcode:
- T1: `pc_out`=1, `mar_in`=1.
- T2: `pc_inc`=1.
- T3: `ram_out`=1, IR load.
REQ-008 LDA (0000): T4 `ir_out`, `mar_in`; T5 `ram_out`, `a_in`; T6 no strobes.
REQ-009 ADD (0001): T4 `ir_out`, `mar_in`; T5 `ram_out`, `b_in`; T6 `alu_out`, `a_in`.
REQ-010 SUB (0010): same as ADD, and `sub`=1 in both T5 and T6.
REQ-011 OUT (1110): T4 `a_out`, `out_in`; T5 and T6 no strobes.
REQ-012 HLT (1111): T4 asserts no strobes; the next state after T4 SHALL be HALT, not T5.
REQ-013 Any other opcode SHALL act as NOP: no strobes in T4–T6; the ring continues to T1.
REQ-014 In HALT: every strobe=0, `halt`=1, `t_state`=000000, IR frozen. Only `reset` leaves HALT.
REQ-015 At most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out` SHALL be high in any state (bus single-driver rule).
REQ-016 `t_state` SHALL be exactly one-hot in T1–T6.

Reset
REQ-017 Asserting `reset` SHALL immediately, without waiting for a clock edge, force state=T1, IR=00000000 and `halt`=0, including mid-instruction or in HALT.
REQ-018 While `reset`=1, outputs SHALL equal the T1 decode: `pc_out`=1, `mar_in`=1, all other strobes 0, `t_state`=000001, `opcode`=0000, `ir_operand`=0000.
REQ-019 The first rising edge after `reset` deasserts SHALL move T1→T2.

Verification
REQ-020 Reset then 6 clocks with `bus_in`=0x0A in T3 → `t_state` 000001,000010,000100,001000,010000,100000; `opcode`=0000, `ir_operand`=1010; T4 `ir_out`+`mar_in`; T5 `ram_out`+`a_in`.
REQ-021 `bus_in`=0x2C at T3 → `opcode`=0010; T5 `ram_out`+`b_in`+`sub`; T6 `alu_out`+`a_in`+`sub`; then back to T1.
REQ-022 `bus_in`=0xE0 at T3 → T4 `a_out`+`out_in`; T5 and T6 all strobes 0.
REQ-023 `bus_in`=0xF0 at T3 → T4 no strobes, then `halt`=1 and `t_state`=0 for 20 further clocks with `bus_in` toggling; IR stays 0xF0; then `reset` pulse → T1 decode with no clock edge.
REQ-024 `bus_in`=0x35 (undefined) → T4–T6 all strobes 0, ring returns to T1; `reset` asserted mid-T5 between edges of an ADD → outputs switch to the T1 decode at once.
REQ-025 In every cycle of all scenarios, the bench SHALL check the single-driver rule of REQ-015.

Source files
------------

// File: rtl/sap_controller.sv
// SAP-1 style control sequencer: six-step T-ring with an instruction register,
// decoding the control word as a pure function of step and IR.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_T1   | address fetch: PC onto bus, latch into MAR
// ST_T2   | increment PC
// ST_T3   | RAM onto bus, latch into IR
// ST_T4   | execute step 1 (operand address / OUT / HLT)
// ST_T5   | execute step 2
// ST_T6   | execute step 3
// ST_HALT | stopped by HLT, left only through reset
module sap_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] bus_in,
    output logic [3:0] ir_operand,
    output logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       sub,
    output logic       out_in,
    output logic       halt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_T1;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign opcode     = ir_q[7:4];
    assign ir_operand = ir_q[3:0];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                ir_d    = bus_in;
                state_d = ST_T4;
            end
            // HLT is known by T4 because IR was loaded on the edge ending T3
            ST_T4:   state_d = (ir_q[7:4] == OP_HLT) ? ST_HALT : ST_T5;
            ST_T5:   state_d = ST_T6;
            ST_T6:   state_d = ST_T1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T1;
        endcase
    end

    always_comb begin
        t_state = 6'b000000;
        pc_out  = 1'b0;
        pc_inc  = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ir_out  = 1'b0;
        a_in    = 1'b0;
        a_out   = 1'b0;
        b_in    = 1'b0;
        alu_out = 1'b0;
        sub     = 1'b0;
        out_in  = 1'b0;
        halt    = 1'b0;
        case (state_q)
            ST_T1: begin
                t_state = 6'b000001;
                pc_out  = 1'b1;
                mar_in  = 1'b1;
            end
            ST_T2: begin
                t_state = 6'b000010;
                pc_inc  = 1'b1;
            end
            ST_T3: begin
                t_state = 6'b000100;
                ram_out = 1'b1;
            end
            ST_T4: begin
                t_state = 6'b001000;
                case (ir_q[7:4])
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_OUT: begin
                        a_out  = 1'b1;
                        out_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                t_state = 6'b010000;
                case (ir_q[7:4])
                    OP_LDA: begin
                        ram_out = 1'b1;
                        a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                        sub     = (ir_q[7:4] == OP_SUB);
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                t_state = 6'b100000;
                if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
                    alu_out = 1'b1;
                    a_in    = 1'b1;
                    sub     = (ir_q[7:4] == OP_SUB);
                end
            end
            ST_HALT: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: per-cycle expectations are queued by the
// stimulus and consumed by a negedge monitor.
module tb_sap_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic [3:0] ir_operand, opcode;
    logic [5:0] t_state;
    logic pc_out, pc_inc, mar_in, ram_out, ir_out, a_in, a_out, b_in, alu_out, sub, out_in, halt;

    sap_controller dut (
        .clock(clock), .reset(reset), .bus_in(bus_in),
        .ir_operand(ir_operand), .opcode(opcode), .t_state(t_state),
        .pc_out(pc_out), .pc_inc(pc_inc), .mar_in(mar_in), .ram_out(ram_out),
        .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
        .alu_out(alu_out), .sub(sub), .out_in(out_in), .halt(halt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  t;
        logic [10:0] s;
        logic        h;
        logic [3:0]  op;
        logic [3:0]  opd;
    } rec_t;

    localparam logic [10:0] PC_OUT  = 11'b10000000000;
    localparam logic [10:0] PC_INC  = 11'b01000000000;
    localparam logic [10:0] MAR_IN  = 11'b00100000000;
    localparam logic [10:0] RAM_OUT = 11'b00010000000;
    localparam logic [10:0] IR_OUT  = 11'b00001000000;
    localparam logic [10:0] A_IN    = 11'b00000100000;
    localparam logic [10:0] A_OUT   = 11'b00000010000;
    localparam logic [10:0] B_IN    = 11'b00000001000;
    localparam logic [10:0] ALU_OUT = 11'b00000000100;
    localparam logic [10:0] SUB     = 11'b00000000010;
    localparam logic [10:0] OUT_IN  = 11'b00000000001;

    rec_t act;
    assign act = {t_state, pc_out, pc_inc, mar_in, ram_out, ir_out, a_in, a_out,
                  b_in, alu_out, sub, out_in, halt, opcode, ir_operand};

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: step 1..6 of the current instruction, IR, halted flag
    int         m_step = 1;
    logic [7:0] m_ir   = 8'h00;
    logic       m_halt = 1'b0;

    function automatic rec_t expected(int step, logic [7:0] ir, logic halted);
        rec_t r;
        logic [10:0] s;
        s = '0;
        r.h = halted;
        r.op = ir[7:4];
        r.opd = ir[3:0];
        if (halted) begin
            r.t = 6'b0;
        end else begin
            r.t = 6'(1 << (step - 1));
            if (step == 1) s = PC_OUT | MAR_IN;
            else if (step == 2) s = PC_INC;
            else if (step == 3) s = RAM_OUT;
            else begin
                case (ir[7:4])
                    4'h0: s = (step == 4) ? (IR_OUT | MAR_IN) : (step == 5) ? (RAM_OUT | A_IN) : '0;
                    4'h1: s = (step == 4) ? (IR_OUT | MAR_IN) : (step == 5) ? (RAM_OUT | B_IN) : (ALU_OUT | A_IN);
                    4'h2: s = (step == 4) ? (IR_OUT | MAR_IN) : (step == 5) ? (RAM_OUT | B_IN | SUB) : (ALU_OUT | A_IN | SUB);
                    4'hE: s = (step == 4) ? (A_OUT | OUT_IN) : '0;
                    default: s = '0;
                endcase
            end
        end
        r.s = s;
        return r;
    endfunction

    function automatic void compare(string name, rec_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got t=%b s=%b h=%b op=%h opd=%h, need t=%b s=%b h=%b op=%h opd=%h",
                     name, act.t, act.s, act.h, act.op, act.opd, e.t, e.s, e.h, e.op, e.opd);
        end
    endfunction

    always @(negedge clock) begin
        total++;
        if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
            bad++;
            $display("FAIL bus_drivers at %0t: pc=%b ram=%b ir=%b a=%b alu=%b need at most one",
                     $time, pc_out, ram_out, ir_out, a_out, alu_out);
        end
        if (q.size() > 0) compare("cycle", q.pop_front());
    end

    // Entered at posedge+1; expects the current cycle, then advances the model.
    task automatic do_cycle(input logic [7:0] b);
        bus_in = b;
        q.push_back(expected(m_step, m_ir, m_halt));
        @(posedge clock);
        if (!m_halt) begin
            if (m_step == 3) m_ir = b;
            if (m_step == 4 && m_ir[7:4] == 4'hF) m_halt = 1'b1;
            else m_step = (m_step == 6) ? 1 : m_step + 1;
        end
        #1;
    endtask

    task automatic run_instr(input logic [7:0] b);
        for (int i = 0; i < 6; i++) begin
            if (m_halt) break;
            do_cycle((m_step == 3) ? b : 8'($urandom));
        end
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b1;
        m_step = 1;
        m_ir = 8'h00;
        m_halt = 1'b0;
        #1;
        compare(name, expected(1, 8'h00, 1'b0));
        @(posedge clock);
        #1;
        compare({name, "_held"}, expected(1, 8'h00, 1'b0));
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        apply_reset("reset_initial");
        run_instr(8'h0A);
        run_instr(8'h2C);
        run_instr(8'hE0);
        run_instr(8'h35);
        run_instr(8'h1F);
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7:4] = 4'($urandom_range(0, 14));
            run_instr(b);
        end
        // ADD interrupted by reset between edges of T5
        for (int i = 0; i < 4; i++) do_cycle((m_step == 3) ? 8'h13 : 8'($urandom));
        #2;
        compare("add_t5", expected(5, 8'h13, 1'b0));
        apply_reset("reset_mid_t5");
        run_instr(8'h0A);
        run_instr(8'hF0);
        for (int i = 0; i < 20; i++) do_cycle(i[0] ? 8'hFF : 8'h00);
        #2;
        apply_reset("reset_from_halt");
        run_instr(8'h2C);
        @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d left, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by %0t, need finish", $time);
        $fatal(1, "timeout");
    end

endmodule
